// File: rtl/sysid_checker.sv
// sysid_checker: Avalon-MM master that reads the system ID slave (ID word at
// address 0, timestamp word at address 1) on request and latches whether both
// match the build-time expected values. A stalled slave is guarded by a timeout.
//
// Ports:
//   clock, reset          single rising-edge clock, asynchronous active-high reset
//   start                 one-cycle check request, ignored unless idle
//   address, read         Avalon-MM master command (word address, read strobe)
//   readdata, waitrequest Avalon-MM slave response / stall
//   busy                  high while a read is outstanding
//   done                  one-cycle pulse, results valid in that cycle
//   id_ok, ts_ok          captured words equal their expected values
//   timeout               last check aborted because the slave stalled too long
//   id_value, ts_value    captured words (0 if never captured)
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1319998626,
  parameter logic [15:0] TIMEOUT_CYCLES     = 16'd255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        address,
  output logic        read,
  input  logic [31:0] readdata,
  input  logic        waitrequest,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_ID = 2'd1,
    RD_TS = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] wait_cnt;
  logic        in_read;
  logic        accept;
  logic        stall_limit;
  logic        start_ok;

  // Command outputs are decoded straight from the state register, so an
  // asynchronous reset drops read in the same instant it resets the state.
  assign in_read  = (state == RD_ID) || (state == RD_TS);
  assign accept   = in_read && !waitrequest;
  assign start_ok = (state == IDLE) && start;

  // Abort on the stall cycle that brings the consecutive-stall count up to
  // TIMEOUT_CYCLES. The sum is widened so a saturated counter cannot wrap.
  assign stall_limit = in_read && waitrequest && (TIMEOUT_CYCLES != 16'd0) &&
                       (({1'b0, wait_cnt} + 17'd1) >= {1'b0, TIMEOUT_CYCLES});

  // Next-state and command decode.
  always_comb begin
    state_nxt = state;
    read      = 1'b0;
    address   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RD_ID;
      end
      RD_ID: begin
        read = 1'b1;
        busy = 1'b1;
        if (accept)           state_nxt = RD_TS;
        else if (stall_limit) state_nxt = DONE;
      end
      RD_TS: begin
        read    = 1'b1;
        address = 1'b1;
        busy    = 1'b1;
        if (accept || stall_limit) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Consecutive stall counter: restarts on entry to each read state and
  // saturates at all-ones.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt <= 16'd0;
    end else if ((state_nxt != state) &&
                 ((state_nxt == RD_ID) || (state_nxt == RD_TS))) begin
      wait_cnt <= 16'd0;
    end else if (in_read && waitrequest && (wait_cnt != 16'hFFFF)) begin
      wait_cnt <= wait_cnt + 16'd1;
    end
  end

  // Result registers: cleared when a check is accepted, written as words
  // arrive, then held until the next accepted start.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      id_ok    <= 1'b0;
      ts_ok    <= 1'b0;
      timeout  <= 1'b0;
      id_value <= 32'd0;
      ts_value <= 32'd0;
    end else if (start_ok) begin
      id_ok    <= 1'b0;
      ts_ok    <= 1'b0;
      timeout  <= 1'b0;
      id_value <= 32'd0;
      ts_value <= 32'd0;
    end else if (state == RD_ID) begin
      if (accept)           id_value <= readdata;
      else if (stall_limit) timeout  <= 1'b1;
    end else if (state == RD_TS) begin
      if (accept) begin
        ts_value <= readdata;
        // id_value already holds the ID captured in RD_ID; the timestamp is
        // compared directly from the bus so both flags land on this edge.
        id_ok    <= (id_value == EXPECTED_ID);
        ts_ok    <= (readdata == EXPECTED_TIMESTAMP);
      end else if (stall_limit) begin
        timeout  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sysid_checker.sv
// tb_sysid_checker: directed-vector bench for sysid_checker. One instance runs
// against a modelled zero/stalling slave with the default timeout; a second
// instance with TIMEOUT_CYCLES=4 faces a slave whose waitrequest is stuck high.
module tb_sysid_checker;

  logic        clock;
  logic        reset;
  logic        start;
  logic        address;
  logic        read;
  logic [31:0] readdata;
  logic        waitrequest;
  logic        busy;
  logic        done;
  logic        id_ok;
  logic        ts_ok;
  logic        timeout;
  logic [31:0] id_value;
  logic [31:0] ts_value;

  logic        to_start;
  logic        to_address;
  logic        to_read;
  logic [31:0] to_readdata;
  logic        to_waitrequest;
  logic        to_busy;
  logic        to_done;
  logic        to_id_ok;
  logic        to_ts_ok;
  logic        to_timeout;
  logic [31:0] to_id_value;
  logic [31:0] to_ts_value;

  logic [31:0] id_word;
  logic [31:0] ts_word;

  int vectors;
  int miscompares;
  int done_count;

  // Slave model: word selected by address, combinational response.
  assign readdata    = address ? ts_word : id_word;
  assign to_readdata = 32'h1234_5678;

  sysid_checker #(
    .EXPECTED_ID       (32'd0),
    .EXPECTED_TIMESTAMP(32'h4EAD94A2),
    .TIMEOUT_CYCLES    (16'd255)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .address    (address),
    .read       (read),
    .readdata   (readdata),
    .waitrequest(waitrequest),
    .busy       (busy),
    .done       (done),
    .id_ok      (id_ok),
    .ts_ok      (ts_ok),
    .timeout    (timeout),
    .id_value   (id_value),
    .ts_value   (ts_value)
  );

  sysid_checker #(
    .EXPECTED_ID       (32'd0),
    .EXPECTED_TIMESTAMP(32'h4EAD94A2),
    .TIMEOUT_CYCLES    (16'd4)
  ) dut_to (
    .clock      (clock),
    .reset      (reset),
    .start      (to_start),
    .address    (to_address),
    .read       (to_read),
    .readdata   (to_readdata),
    .waitrequest(to_waitrequest),
    .busy       (to_busy),
    .done       (to_done),
    .id_ok      (to_id_ok),
    .ts_ok      (to_ts_ok),
    .timeout    (to_timeout),
    .id_value   (to_id_value),
    .ts_value   (to_ts_value)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    done_count     = 0;
    reset          = 1'b1;
    start          = 1'b0;
    waitrequest    = 1'b0;
    to_start       = 1'b0;
    to_waitrequest = 1'b1;
    id_word        = 32'd0;
    ts_word        = 32'h4EAD94A2;

    // Reset state
    step();
    step();
    chk1 ("rst_read",     read,     1'b0);
    chk1 ("rst_address",  address,  1'b0);
    chk1 ("rst_busy",     busy,     1'b0);
    chk1 ("rst_done",     done,     1'b0);
    chk1 ("rst_id_ok",    id_ok,    1'b0);
    chk1 ("rst_ts_ok",    ts_ok,    1'b0);
    chk1 ("rst_timeout",  timeout,  1'b0);
    chk32("rst_id_value", id_value, 32'd0);
    chk32("rst_ts_value", ts_value, 32'd0);
    reset = 1'b0;
    step();

    // Zero-wait check, matching words
    start = 1'b1;
    step();                              // cycle 1
    start = 1'b0;
    chk1("zw_c1_read",    read,    1'b1);
    chk1("zw_c1_address", address, 1'b0);
    chk1("zw_c1_busy",    busy,    1'b1);
    chk1("zw_c1_done",    done,    1'b0);
    step();                              // cycle 2
    chk1("zw_c2_read",    read,    1'b1);
    chk1("zw_c2_address", address, 1'b1);
    chk1("zw_c2_busy",    busy,    1'b1);
    step();                              // cycle 3
    chk1 ("zw_c3_done",     done,     1'b1);
    chk1 ("zw_c3_busy",     busy,     1'b0);
    chk1 ("zw_c3_read",     read,     1'b0);
    chk1 ("zw_id_ok",       id_ok,    1'b1);
    chk1 ("zw_ts_ok",       ts_ok,    1'b1);
    chk1 ("zw_timeout",     timeout,  1'b0);
    chk32("zw_id_value",    id_value, 32'd0);
    chk32("zw_ts_value",    ts_value, 32'h4EAD94A2);
    step();                              // cycle 4: results hold
    chk1 ("zw_c4_done",     done,     1'b0);
    chk1 ("zw_hold_ts_ok",  ts_ok,    1'b1);
    chk32("zw_hold_ts_val", ts_value, 32'h4EAD94A2);

    // Timestamp off by one
    ts_word = 32'h4EAD94A3;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();                              // cycle 3
    chk1 ("bad_ts_done",     done,     1'b1);
    chk1 ("bad_ts_ts_ok",    ts_ok,    1'b0);
    chk1 ("bad_ts_id_ok",    id_ok,    1'b1);
    chk32("bad_ts_ts_value", ts_value, 32'h4EAD94A3);
    ts_word = 32'h4EAD94A2;
    step();

    // Three stall cycles on each read
    start = 1'b1;
    step();                              // cycle 1
    start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      waitrequest = ((c == 4) || (c == 8)) ? 1'b0 : 1'b1;
      chk1("stall_read",    read,    1'b1);
      chk1("stall_address", address, (c >= 5));
      chk1("stall_done",    done,    1'b0);
      step();
    end
    waitrequest = 1'b0;                  // cycle 9
    chk1 ("stall_c9_done", done,     1'b1);
    chk1 ("stall_id_ok",   id_ok,    1'b1);
    chk1 ("stall_ts_ok",   ts_ok,    1'b1);
    chk1 ("stall_timeout", timeout,  1'b0);
    chk32("stall_ts_val",  ts_value, 32'h4EAD94A2);
    step();

    // Stuck waitrequest against TIMEOUT_CYCLES=4
    to_start = 1'b1;
    step();                              // cycle 1
    to_start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk1("to_stall_read",    to_read,    1'b1);
      chk1("to_stall_address", to_address, 1'b0);
      chk1("to_stall_done",    to_done,    1'b0);
      step();
    end
    chk1 ("to_done",     to_done,     1'b1);   // cycle 5
    chk1 ("to_read",     to_read,     1'b0);
    chk1 ("to_timeout",  to_timeout,  1'b1);
    chk1 ("to_id_ok",    to_id_ok,    1'b0);
    chk1 ("to_ts_ok",    to_ts_ok,    1'b0);
    chk32("to_id_value", to_id_value, 32'd0);
    chk32("to_ts_value", to_ts_value, 32'd0);
    step();
    chk1 ("to_hold_timeout", to_timeout, 1'b1);
    chk1 ("to_after_done",   to_done,    1'b0);

    // start repeated while busy and in the done cycle
    done_count = 0;
    for (int c = 0; c <= 6; c++) begin
      start = (c <= 3) ? 1'b1 : 1'b0;    // c=0 is the accepting cycle
      step();
      if (done) done_count++;
      if (c >= 3) chk1("restart_read_idle", read, 1'b0);
    end
    start = 1'b0;
    chk32("restart_done_count", done_count, 32'd1);

    // Reset during RD_TS, then a normal check
    id_word = 32'hA5A5_0001;
    start = 1'b1;
    step();                              // cycle 1
    start = 1'b0;
    step();                              // cycle 2, RD_TS
    chk1 ("mid_rst_pre_read",  read,     1'b1);
    chk32("mid_rst_pre_idval", id_value, 32'hA5A5_0001);
    reset = 1'b1;
    #1;
    chk1 ("mid_rst_read",     read,     1'b0);
    chk1 ("mid_rst_address",  address,  1'b0);
    chk1 ("mid_rst_busy",     busy,     1'b0);
    chk1 ("mid_rst_done",     done,     1'b0);
    chk1 ("mid_rst_id_ok",    id_ok,    1'b0);
    chk1 ("mid_rst_ts_ok",    ts_ok,    1'b0);
    chk1 ("mid_rst_timeout",  timeout,  1'b0);
    chk32("mid_rst_id_value", id_value, 32'd0);
    chk32("mid_rst_ts_value", ts_value, 32'd0);
    step();
    reset   = 1'b0;
    id_word = 32'd0;
    step();
    chk1("post_rst_no_done", done, 1'b0);
    step();
    chk1("post_rst_no_done2", done, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();                              // cycle 3
    chk1 ("post_rst_done",   done,     1'b1);
    chk1 ("post_rst_id_ok",  id_ok,    1'b1);
    chk1 ("post_rst_ts_ok",  ts_ok,    1'b1);
    chk32("post_rst_ts_val", ts_value, 32'h4EAD94A2);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
